// File: rtl/kbd_decoder.sv
// PS/2 Set-2 scan-code decoder: pops bytes from the receive FIFO, tracks the
// E0/F0 prefixes and keeps the most recently pressed held key plus a press count.
module kbd_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] key_count,
    output logic             ovf_seen
);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t           r_state;
    logic             r_nextdata_n;
    logic [7:0]       r_byte;
    logic             r_key_valid;
    logic [7:0]       r_key_code;
    logic             r_key_ext;
    logic [CNT_W-1:0] r_key_count;
    logic             r_ovf_seen;

    logic w_consume;
    logic w_is_code;
    logic w_is_break;
    logic w_code_ext;
    logic w_match;

    assign w_consume  = ps2_ready && r_nextdata_n;
    // Bytes 0x00 and 0xE1..0xFF (F0 excluded earlier) are noise, not key codes.
    assign w_is_code  = (r_byte != 8'h00) && (r_byte < 8'hE1);
    assign w_is_break = (r_state == BRK) || (r_state == EXT_BRK);
    assign w_code_ext = (r_state == EXT) || (r_state == EXT_BRK);
    assign w_match    = r_key_valid && (r_key_ext == w_code_ext) && (r_key_code == r_byte);

    // The byte is captured when consumed and decoded during the pop cycle that follows.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_nextdata_n <= 1'b1;
            r_byte       <= 8'h00;
            r_key_valid  <= 1'b0;
            r_key_code   <= 8'h00;
            r_key_ext    <= 1'b0;
            r_key_count  <= '0;
            r_ovf_seen   <= 1'b0;
        end else begin
            if (ps2_overflow) begin
                r_ovf_seen <= 1'b1;
            end

            if (w_consume) begin
                r_byte       <= ps2_data;
                r_nextdata_n <= 1'b0;
            end else begin
                r_nextdata_n <= 1'b1;
            end

            if (!r_nextdata_n) begin
                if (r_byte == 8'hE0) begin
                    r_state <= EXT;
                end else if (r_byte == 8'hF0) begin
                    if (r_state == IDLE) begin
                        r_state <= BRK;
                    end else if (r_state == EXT) begin
                        r_state <= EXT_BRK;
                    end
                end else begin
                    r_state <= IDLE;
                    if (w_is_code) begin
                        if (w_is_break) begin
                            if (w_match) begin
                                r_key_valid <= 1'b0;
                            end
                        end else if (!w_match) begin
                            r_key_valid <= 1'b1;
                            r_key_code  <= r_byte;
                            r_key_ext   <= w_code_ext;
                            r_key_count <= r_key_count + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Extended keys never have a printable mapping.
    always_comb begin
        key_ascii = 8'h00;
        if (!r_key_ext) begin
            case (r_key_code)
                8'h1C: key_ascii = 8'h61;
                8'h32: key_ascii = 8'h62;
                8'h21: key_ascii = 8'h63;
                8'h23: key_ascii = 8'h64;
                8'h24: key_ascii = 8'h65;
                8'h2B: key_ascii = 8'h66;
                8'h34: key_ascii = 8'h67;
                8'h33: key_ascii = 8'h68;
                8'h43: key_ascii = 8'h69;
                8'h3B: key_ascii = 8'h6A;
                8'h42: key_ascii = 8'h6B;
                8'h4B: key_ascii = 8'h6C;
                8'h3A: key_ascii = 8'h6D;
                8'h31: key_ascii = 8'h6E;
                8'h44: key_ascii = 8'h6F;
                8'h4D: key_ascii = 8'h70;
                8'h15: key_ascii = 8'h71;
                8'h2D: key_ascii = 8'h72;
                8'h1B: key_ascii = 8'h73;
                8'h2C: key_ascii = 8'h74;
                8'h3C: key_ascii = 8'h75;
                8'h2A: key_ascii = 8'h76;
                8'h1D: key_ascii = 8'h77;
                8'h22: key_ascii = 8'h78;
                8'h35: key_ascii = 8'h79;
                8'h1A: key_ascii = 8'h7A;
                8'h45: key_ascii = 8'h30;
                8'h16: key_ascii = 8'h31;
                8'h1E: key_ascii = 8'h32;
                8'h26: key_ascii = 8'h33;
                8'h25: key_ascii = 8'h34;
                8'h2E: key_ascii = 8'h35;
                8'h36: key_ascii = 8'h36;
                8'h3D: key_ascii = 8'h37;
                8'h3E: key_ascii = 8'h38;
                8'h46: key_ascii = 8'h39;
                8'h29: key_ascii = 8'h20;
                8'h5A: key_ascii = 8'h0D;
                default: key_ascii = 8'h00;
            endcase
        end
    end

    assign nextdata_n = r_nextdata_n;
    assign key_valid  = r_key_valid;
    assign key_code   = r_key_code;
    assign key_ext    = r_key_ext;
    assign key_count  = r_key_count;
    assign ovf_seen   = r_ovf_seen;

endmodule

// File: tb/tb_kbd_decoder.sv
// Scoreboard bench for kbd_decoder: a FIFO model feeds bytes, a key-level
// reference model predicts the outputs after every pop, and a monitor compares.
module tb_kbd_decoder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_ready = 1'b0;
    logic       ps2_overflow = 1'b0;
    logic       nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic [7:0] key_count;
    logic       ovf_seen;

    kbd_decoder #(.CNT_W(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ps2_data     (ps2_data),
        .ps2_ready    (ps2_ready),
        .ps2_overflow (ps2_overflow),
        .nextdata_n   (nextdata_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_ascii    (key_ascii),
        .key_count    (key_count),
        .ovf_seen     (ovf_seen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
        logic       ext;
        logic [7:0] ascii;
        logic [7:0] count;
    } exp_t;

    logic [7:0] fifoQ[$];
    exp_t       expQ[$];
    int         total = 0;
    int         bad = 0;
    int         popCount = 0;
    logic [7:0] asciiOf [256];

    // Reference model state: the held key and the pending prefix flags.
    logic       mValid, mExt, pendExt, pendBrk;
    logic [7:0] mCode, mCount;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic resetModel();
        mValid = 1'b0; mExt = 1'b0; pendExt = 1'b0; pendBrk = 1'b0;
        mCode = 8'h00; mCount = 8'h00;
        fifoQ.delete();
        expQ.delete();
    endtask

    task automatic modelByte(input logic [7:0] b);
        exp_t e;
        if (b == 8'hE0) begin
            pendExt = 1'b1;
            pendBrk = 1'b0;
        end else if (b == 8'hF0) begin
            pendBrk = 1'b1;
        end else begin
            if (b != 8'h00 && b < 8'hE1) begin
                if (!pendBrk) begin
                    if (!(mValid && mCode == b && mExt == pendExt)) begin
                        mValid = 1'b1;
                        mCode  = b;
                        mExt   = pendExt;
                        mCount = mCount + 8'd1;
                    end
                end else if (mValid && mCode == b && mExt == pendExt) begin
                    mValid = 1'b0;
                end
            end
            pendExt = 1'b0;
            pendBrk = 1'b0;
        end
        e.valid = mValid;
        e.code  = mCode;
        e.ext   = mExt;
        e.ascii = mExt ? 8'h00 : asciiOf[mCode];
        e.count = mCount;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifoQ.push_back(b);
        modelByte(b);
    endtask

    // FIFO model: the head is removed at the end of each pop cycle.
    always @(negedge clk) begin
        if (resetn === 1'b1 && nextdata_n === 1'b0 && fifoQ.size() > 0) begin
            void'(fifoQ.pop_front());
            popCount++;
        end
        ps2_ready = (fifoQ.size() > 0);
        ps2_data  = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
    end

    // Monitor: each pop cycle must be followed by the predicted outputs and a single-cycle strobe.
    always begin
        @(negedge clk);
        if (resetn === 1'b1 && nextdata_n === 1'b0) begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pop: got pop expected none");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("mon_valid", 32'(key_valid), 32'(e.valid));
                checkOutput("mon_code",  32'(key_code),  32'(e.code));
                checkOutput("mon_ext",   32'(key_ext),   32'(e.ext));
                checkOutput("mon_ascii", 32'(key_ascii), 32'(e.ascii));
                checkOutput("mon_count", 32'(key_count), 32'(e.count));
            end
            @(negedge clk);
            checkOutput("pop_width", 32'(nextdata_n), 32'd1);
        end
    end

    task automatic waitDrain(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (fifoQ.size() == 0 && expQ.size() == 0 && nextdata_n === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got fifo=%0d exp=%0d expected 0", fifoQ.size(), expQ.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        resetn = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic checkState(input string tag, input logic v, input logic [7:0] c, input logic x,
                              input logic [7:0] a, input logic [7:0] n);
        checkOutput({tag, "_valid"}, 32'(key_valid), 32'(v));
        checkOutput({tag, "_code"},  32'(key_code),  32'(c));
        checkOutput({tag, "_ext"},   32'(key_ext),   32'(x));
        checkOutput({tag, "_ascii"}, 32'(key_ascii), 32'(a));
        checkOutput({tag, "_count"}, 32'(key_count), 32'(n));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_nextdata_n"}, 32'(nextdata_n), 32'd1);
        checkOutput({tag, "_ovf"},        32'(ovf_seen),   32'd0);
        checkState(tag, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] letterCodes [26];
        logic [7:0] digitCodes [10];
        logic [7:0] pool [8];
        int p0;

        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] letterCodes [26];
        logic [7:0] digitCodes [10];
        logic [7:0] pool [8];
        int p0;

        letterCodes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        digitCodes  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        pool        = '{8'h1C, 8'h32, 8'h75, 8'h29, 8'h5A, 8'h45, 8'h6B, 8'h1A};
        for (int i = 0; i < 256; i++) asciiOf[i] = 8'h00;
        for (int i = 0; i < 26; i++) asciiOf[letterCodes[i]] = 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) asciiOf[digitCodes[i]] = 8'h30 + 8'(i);
        asciiOf[8'h29] = 8'h20;
        asciiOf[8'h5A] = 8'h0D;

        resetModel();
        repeat (2) @(negedge clk);
        checkResetValues("rst");
        resetn = 1'b1;
        @(negedge clk);

        // Single make of 'a'
        p0 = popCount;
        applyStimulus(8'h1C);
        waitDrain(100);
        checkOutput("s1_pops", 32'(popCount - p0), 32'd1);
        checkState("s1", 1'b1, 8'h1C, 1'b0, 8'h61, 8'd1);

        // Typematic repeats then release
        doReset();
        p0 = popCount;
        applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        waitDrain(200);
        checkOutput("s2_pops", 32'(popCount - p0), 32'd5);
        checkState("s2", 1'b0, 8'h1C, 1'b0, 8'h61, 8'd1);

        // Last press wins; break of the replaced key is ignored
        doReset();
        applyStimulus(8'h1C); applyStimulus(8'h32); applyStimulus(8'hF0); applyStimulus(8'h1C);
        waitDrain(200);
        checkState("s3a", 1'b1, 8'h32, 1'b0, 8'h62, 8'd2);
        applyStimulus(8'hF0); applyStimulus(8'h32);
        waitDrain(200);
        checkState("s3b", 1'b0, 8'h32, 1'b0, 8'h62, 8'd2);

        // Extended key: plain break ignored, extended break releases
        doReset();
        applyStimulus(8'hE0); applyStimulus(8'h75);
        waitDrain(200);
        checkState("s4a", 1'b1, 8'h75, 1'b1, 8'h00, 8'd1);
        applyStimulus(8'hF0); applyStimulus(8'h75);
        waitDrain(200);
        checkState("s4b", 1'b1, 8'h75, 1'b1, 8'h00, 8'd1);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        waitDrain(200);
        checkState("s4c", 1'b0, 8'h75, 1'b1, 8'h00, 8'd1);

        // Reset mid-prefix clears asynchronously and drops the pending F0
        doReset();
        applyStimulus(8'h1C); applyStimulus(8'hF0);
        waitDrain(200);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        checkResetValues("s5rst");
        resetModel();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        applyStimulus(8'h1C);
        waitDrain(100);
        checkState("s5", 1'b1, 8'h1C, 1'b0, 8'h61, 8'd1);

        // Counter wrap after 256 alternating presses, then sticky overflow
        doReset();
        for (int i = 0; i < 256; i++) applyStimulus((i % 2 == 1) ? 8'h32 : 8'h1C);
        waitDrain(2000);
        checkState("s6", 1'b1, 8'h32, 1'b0, 8'h62, 8'd0);
        checkOutput("s6_ovf_before", 32'(ovf_seen), 32'd0);
        ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("s6_ovf_held", 32'(ovf_seen), 32'd1);
        doReset();
        checkOutput("s6_ovf_cleared", 32'(ovf_seen), 32'd0);

        // Randomized byte stream with prefixes, junk bytes and idle gaps
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      applyStimulus(8'hE0);
            else if (r == 1) applyStimulus(8'hF0);
            else if (r == 2) applyStimulus(8'($urandom_range(0, 255)));
            else             applyStimulus(pool[$urandom_range(0, 7)]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        waitDrain(5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kbd_decoder.md
KBD_DECODER -- requirements
Module: kbd_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of the key-press counter.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous and active-low.
REQ-004 Port: ps2_data  input  8  head byte of the keyboard receive FIFO.
REQ-005 Port: ps2_ready  input  1  FIFO non-empty; ps2_data valid.
REQ-006 Port: ps2_overflow  input  1  FIFO overflow indication.
REQ-007 Port: nextdata_n  output  1  active-low pop strobe to the FIFO.
REQ-008 Port: key_valid  output  1  a key is currently held.
REQ-009 Port: key_code  output  8  Set-2 make code of the last-pressed held key.
REQ-010 Port: key_ext  output  1  held key was E0-prefixed.
REQ-011 Port: key_ascii  output  8  lowercase ASCII of the held key, 0x00 if unmapped or extended.
REQ-012 Port: key_count  output  CNT_W  number of new key presses since reset.
REQ-013 Port: ovf_seen  output  1  sticky overflow flag.

Function
REQ-014 Pop handshake: in any cycle with ps2_ready=1 and nextdata_n=1, the block SHALL consume ps2_data and drive nextdata_n=0 in the following cycle for exactly one cycle.
REQ-015 After a pop cycle, nextdata_n SHALL return to 1 for at least one cycle, so throughput is at most one byte per 2 cycles; ps2_ready SHALL be ignored while nextdata_n=0.
REQ-016 The FSM SHALL have the states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 then F0 seen).
REQ-017 Transitions on a consumed byte: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any other byte SHALL be a code, processed as a make (from IDLE or EXT) or a break (from BRK or EXT_BRK), and the FSM SHALL return to IDLE.
REQ-018 For a make with code c and ext e: if key_valid=1 and {key_ext,key_code}=={e,c}, the byte SHALL be treated as typematic repeat and leave all outputs unchanged.
REQ-019 Otherwise the block SHALL set key_valid=1, key_code=c and key_ext=e, and increment key_count by 1, wrapping modulo 2^CNT_W.
REQ-020 A make of a different key while one is held SHALL replace the held key (last-press-wins) and SHALL count.
REQ-021 A break matching {key_ext,key_code} SHALL clear key_valid in the cycle after consumption; key_code and key_ext SHALL retain their values.
REQ-022 A break for a non-held key SHALL be ignored.
REQ-023 E0 or F0 received in EXT, BRK or EXT_BRK SHALL be handled as follows: E0 SHALL move the FSM to EXT; F0 received in BRK or EXT_BRK SHALL keep the current state.
REQ-024 The byte 0x00, and any byte from 0xE1 to 0xFF other than F0, SHALL be discarded and the FSM SHALL return to IDLE.
REQ-025 key_ascii SHALL be combinational from key_code and key_ext.
REQ-026 The ASCII map SHALL be Set-2: a-z -> 0x61-0x7A, 0-9 -> 0x30-0x39, space 0x29 -> 0x20, enter 0x5A -> 0x0D.
REQ-027 All other codes, and all codes with key_ext=1, SHALL map to 0x00.
REQ-028 Latency: outputs SHALL update on the clock edge that ends the pop cycle, i.e. 2 cycles after ps2_ready rises.
REQ-029 ovf_seen SHALL be set on any cycle with ps2_overflow=1 and cleared only by reset.

Reset
REQ-030 While resetn=0: FSM=IDLE, nextdata_n=1, key_valid=0, key_code=0x00, key_ext=0, key_count=0, ovf_seen=0; these SHALL apply asynchronously.
REQ-031 Reset asserted mid-sequence (e.g. after F0) SHALL discard the partial prefix; the first byte consumed after reset SHALL be decoded from IDLE.

Verification
REQ-032 The bench SHALL cover: FIFO supplies 1C -> one nextdata_n low pulse; key_valid=1, key_code=1C, key_ascii=0x61, key_count=1.
REQ-033 The bench SHALL cover: 1C,1C,1C,F0,1C -> key_count=1, key_valid=0, key_code=1C, 5 pops.
REQ-034 The bench SHALL cover: 1C then 32 held, F0 1C -> key_code=32, key_ascii=0x62, key_valid=1, key_count=2; then F0 32 -> key_valid=0.
REQ-035 The bench SHALL cover: E0,75 -> key_ext=1, key_code=75, key_ascii=0x00; then E0,F0,75 -> key_valid=0; a plain F0,75 while E0 75 is held SHALL be ignored.
REQ-036 The bench SHALL cover: F0 consumed, then resetn pulsed low mid-cycle -> outputs at reset values immediately; then 1C -> make, key_count=1.
REQ-037 The bench SHALL cover: CNT_W=8 with 256 distinct alternating presses -> key_count wraps to 0; ps2_overflow pulse -> ovf_seen=1 held until reset.
